// File: rtl/dvp_capture_window.sv
// dvp_capture_window: DVP byte-to-pixel capture with frame skip, crop window, decimation and error flags
module dvp_capture_window #(
  parameter int DATA_W      = 8,
  parameter int BPP         = 2,
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int SKIP_FRAMES = 3,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [DATA_W-1:0]     din,
  input  logic [X_W-1:0]        crop_x0,
  input  logic [X_W-1:0]        crop_x1,
  input  logic [Y_W-1:0]        crop_y0,
  input  logic [Y_W-1:0]        crop_y1,
  input  logic [1:0]            decim,
  input  logic                  err_clr,
  output logic                  pix_valid,
  output logic [DATA_W*BPP-1:0] pix_data,
  output logic [X_W-1:0]        pix_x,
  output logic [Y_W-1:0]        pix_y,
  output logic                  sof,
  output logic                  line_done,
  output logic                  eof,
  output logic                  frame_act,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  err_part,
  output logic                  err_ovf
);
  localparam int PW   = DATA_W * BPP;
  localparam int SK_W = $clog2(SKIP_FRAMES + 2);
  localparam int BI_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [SK_W-1:0] SKIP_N = SK_W'(SKIP_FRAMES);
  localparam logic [BI_W-1:0] LAST_B = BI_W'(BPP - 1);
  localparam logic [X_W-1:0]  X_MAX  = {X_W{1'b1}};
  localparam logic [Y_W-1:0]  Y_MAX  = {Y_W{1'b1}};
  typedef enum logic [1:0] {IDLE, SKIP, ACTIVE} state_t;
  state_t          r_state;
  logic            r_vs_d, r_hr_d, r_sof_pend, r_xsat;
  logic [SK_W-1:0] r_skip;
  logic [BI_W-1:0] r_bidx;
  logic [PW-1:0]   r_acc;
  logic [X_W-1:0]  r_x, r_x0, r_x1;
  logic [Y_W-1:0]  r_y, r_y0, r_y1;
  logic [1:0]      r_decim;
  logic            w_vs_fall, w_vs_rise, w_hr_fall, w_last, w_keep;
  logic [1:0]      w_dec, w_mask;
  logic [PW-1:0]   w_pix;
  logic [X_W-1:0]  w_dx;
  logic [Y_W-1:0]  w_dy;
  assign w_vs_fall = r_vs_d & ~vsync;
  assign w_vs_rise = ~r_vs_d & vsync;
  assign w_hr_fall = r_hr_d & ~href;
  assign w_last    = r_bidx == LAST_B;
  assign w_pix     = PW'({r_acc, din});
  assign w_dec     = (r_decim == 2'd3) ? 2'd2 : r_decim;
  assign w_mask    = (w_dec == 2'd0) ? 2'b00 : (w_dec == 2'd1) ? 2'b01 : 2'b11;
  assign w_dx      = r_x - r_x0;
  assign w_dy      = r_y - r_y0;
  assign w_keep    = (r_x >= r_x0) && (r_x <= r_x1) && (r_y >= r_y0) && (r_y <= r_y1) &&
                     ((r_x[1:0] & w_mask) == 2'b00) && ((r_y[1:0] & w_mask) == 2'b00);
  // Frame FSM, byte assembly, pixel emission and flag bookkeeping; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_vs_d     <= 1'b0;
      r_hr_d     <= 1'b0;
      r_sof_pend <= 1'b0;
      r_xsat     <= 1'b0;
      r_skip     <= '0;
      r_bidx     <= '0;
      r_acc      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_decim    <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      sof        <= 1'b0;
      line_done  <= 1'b0;
      eof        <= 1'b0;
      frame_act  <= 1'b0;
      frame_cnt  <= '0;
      err_part   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      r_vs_d    <= vsync;
      r_hr_d    <= href;
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      line_done <= 1'b0;
      eof       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!enable) r_skip <= '0;
          else if (w_vs_fall) begin
            if (r_skip < SKIP_N) r_state <= SKIP;
            else begin
              r_state    <= ACTIVE;
              frame_act  <= 1'b1;
              r_x0       <= crop_x0;
              r_x1       <= crop_x1;
              r_y0       <= crop_y0;
              r_y1       <= crop_y1;
              r_decim    <= decim;
              r_x        <= '0;
              r_y        <= '0;
              r_bidx     <= '0;
              r_xsat     <= 1'b0;
              r_sof_pend <= 1'b1;
            end
          end
        end
        SKIP: if (w_vs_rise) begin
          r_skip  <= r_skip + SK_W'(1);
          r_state <= IDLE;
        end
        default: begin
          if (w_vs_rise) begin
            r_state   <= IDLE;
            frame_act <= 1'b0;
            eof       <= 1'b1;
            frame_cnt <= frame_cnt + CNT_W'(1);
            r_bidx    <= '0;
          end else if (w_hr_fall) begin
            line_done <= 1'b1;
            r_y       <= (r_y == Y_MAX) ? r_y : r_y + Y_W'(1);
            r_x       <= '0;
            r_xsat    <= 1'b0;
            r_bidx    <= '0;
            if (r_bidx != '0) err_part <= 1'b1;
          end else if (href) begin
            r_acc <= w_pix;
            if (!w_last) r_bidx <= r_bidx + BI_W'(1);
            else begin
              r_bidx <= '0;
              if (r_xsat) err_ovf <= 1'b1;
              else begin
                if (w_keep) begin
                  pix_valid  <= 1'b1;
                  pix_data   <= w_pix;
                  pix_x      <= w_dx >> w_dec;
                  pix_y      <= w_dy >> w_dec;
                  sof        <= r_sof_pend;
                  r_sof_pend <= 1'b0;
                end
                if (r_x == X_MAX) r_xsat <= 1'b1;
                else r_x <= r_x + X_W'(1);
              end
            end
          end
        end
      endcase
      if (err_clr) begin
        err_part <= 1'b0;
        err_ovf  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dvp_capture_window.sv
// tb_dvp_capture_window: randomized frame bench against a line/pixel reference model
module tb_dvp_capture_window;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, vsync = 1'b1, href = 1'b0, err_clr = 1'b0;
  logic [7:0]  din = '0;
  logic [9:0]  x0 = '0, x1 = 10'd1023, y0 = '0, y1 = 10'd1023;
  logic [1:0]  decim = '0;
  logic        pix_valid, sof, line_done, eof, frame_act, err_part, err_ovf;
  logic [15:0] pix_data, frame_cnt;
  logic [9:0]  pix_x, pix_y;
  logic        pv2, sof2, ld2, eof2, fa2, ep2, eo2;
  logic [15:0] pd2, fc2;
  logic [2:0]  px2;
  logic [9:0]  py2;
  typedef struct packed {logic [9:0] x; logic [9:0] y; logic [15:0] d; logic s;} pix_t;
  pix_t        got[$], exq[$];
  int          n_ld, n_eof, n_pix2, n_act;
  int          n_assert = 0, n_fail = 0;
  logic [7:0]  mem [8][24];
  int          mskip = 0;
  logic [15:0] mcnt = '0;
  logic        mpart = 1'b0, movf2 = 1'b0;

  dvp_capture_window dut (
    .clk(clk), .rst(rst), .enable(enable), .vsync(vsync), .href(href), .din(din),
    .crop_x0(x0), .crop_x1(x1), .crop_y0(y0), .crop_y1(y1), .decim(decim), .err_clr(err_clr),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .sof(sof),
    .line_done(line_done), .eof(eof), .frame_act(frame_act), .frame_cnt(frame_cnt),
    .err_part(err_part), .err_ovf(err_ovf));

  dvp_capture_window #(.X_W(3)) dut_x3 (
    .clk(clk), .rst(rst), .enable(enable), .vsync(vsync), .href(href), .din(din),
    .crop_x0(x0[2:0]), .crop_x1(x1[2:0]), .crop_y0(y0), .crop_y1(y1), .decim(decim), .err_clr(err_clr),
    .pix_valid(pv2), .pix_data(pd2), .pix_x(px2), .pix_y(py2), .sof(sof2),
    .line_done(ld2), .eof(eof2), .frame_act(fa2), .frame_cnt(fc2),
    .err_part(ep2), .err_ovf(eo2));

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst) begin
    if (pix_valid) got.push_back({pix_x, pix_y, pix_data, sof});
    if (line_done) n_ld++;
    if (eof) n_eof++;
    if (frame_act) n_act++;
    if (pv2) n_pix2++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input int lines, input int nb);
    bit act;
    int dec, st, np;
    logic first;
    if (!enable) begin mskip = 0; act = 0; end
    else if (mskip < 3) begin mskip++; act = 0; end
    else act = 1;
    exq.delete();
    np = nb / 2;
    dec = (decim == 2'd3) ? 2 : int'(decim);
    st = 1 << dec;
    first = 1'b1;
    if (act) begin
      for (int y = 0; y < lines; y++)
        for (int p = 0; p < np; p++)
          if (p >= x0 && p <= x1 && y >= y0 && y <= y1 && p % st == 0 && y % st == 0) begin
            exq.push_back({10'((p - x0) / st), 10'((y - y0) / st), mem[y][2*p], mem[y][2*p+1], first});
            first = 1'b0;
          end
      mcnt++;
      if (nb % 2 != 0) mpart = 1'b1;
      if (np > 8) movf2 = 1'b1;
    end
    chk("pix_count", 64'(got.size()), 64'(exq.size()));
    for (int i = 0; i < exq.size() && i < got.size(); i++)
      chk($sformatf("pixel%0d", i), 64'(got[i]), 64'(exq[i]));
    chk("line_done", 64'(n_ld), act ? 64'(lines) : 64'd0);
    chk("eof", 64'(n_eof), 64'(act));
    chk("frame_act_seen", 64'(n_act > 0), 64'(act));
    chk("frame_act_idle", 64'(frame_act), 64'd0);
    chk("frame_cnt", 64'(frame_cnt), 64'(mcnt));
    chk("err_part", 64'(err_part), 64'(mpart));
    chk("err_ovf", 64'(err_ovf), 64'd0);
    chk("err_ovf_x3", 64'(eo2), 64'(movf2));
  endtask

  task automatic run_frame(input int lines, input int nb, input bit seq);
    int k = 0;
    for (int l = 0; l < lines; l++)
      for (int i = 0; i < nb; i++) begin
        mem[l][i] = seq ? 8'(k) : 8'($urandom);
        k++;
      end
    got.delete();
    n_ld = 0; n_eof = 0; n_act = 0; n_pix2 = 0;
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < nb; i++) begin
        href = 1'b1;
        din = mem[l][i];
        @(negedge clk);
      end
      href = 1'b0;
      din = '0;
      repeat (2) @(negedge clk);
    end
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    check_frame(lines, nb);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({pix_valid, pix_data, pix_x, pix_y, sof, line_done, eof, frame_act,
                              frame_cnt, err_part, err_ovf}), 64'd0);
    rst = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    // three skipped frames then two captured 4x2 frames
    for (int f = 0; f < 3; f++) run_frame(2, 8, 1'b1);
    run_frame(2, 8, 1'b1);
    chk("first_pixel", got.size() != 0 ? 64'(got[0].d) : 64'hdead, 64'h0001);
    run_frame(2, 8, 1'b1);
    chk("frame_cnt_two", 64'(frame_cnt), 64'd2);
    // crop window on a 4x3 frame
    x0 = 10'd1; x1 = 10'd2; y0 = 10'd1; y1 = 10'd1;
    run_frame(3, 8, 1'b0);
    // decimation by 2 on 8x4, then decim=3 with a crop on 12x6
    x0 = '0; x1 = 10'd1023; y0 = '0; y1 = 10'd1023; decim = 2'd1;
    run_frame(4, 16, 1'b0);
    x0 = 10'd2; x1 = 10'd9; y0 = 10'd1; y1 = 10'd5; decim = 2'd3;
    run_frame(6, 24, 1'b0);
    // inverted crop emits nothing but still ends the frame
    x0 = 10'd5; x1 = 10'd2; y0 = '0; y1 = 10'd1023; decim = 2'd0;
    run_frame(2, 8, 1'b0);
    // partial pixel at line end, then clear
    x0 = '0; x1 = 10'd1023;
    run_frame(2, 7, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mpart = 1'b0; movf2 = 1'b0;
    chk("err_part_clr", 64'(err_part), 64'd0);
    chk("err_ovf_x3_clr", 64'(eo2), 64'd0);
    // 9-pixel lines overflow the 3-bit column counter
    run_frame(2, 18, 1'b0);
    chk("x3_pixels", 64'(n_pix2), 64'd16);
    // randomized crop/decim/size frames
    for (int r = 0; r < 4; r++) begin
      x0 = 10'($urandom_range(0, 6)); x1 = 10'($urandom_range(0, 11));
      y0 = 10'($urandom_range(0, 3)); y1 = 10'($urandom_range(0, 7));
      decim = 2'($urandom_range(0, 3));
      run_frame($urandom_range(1, 8), $urandom_range(1, 24), 1'b0);
    end
    // enable low restarts the skip count
    x0 = '0; x1 = 10'd1023; y0 = '0; y1 = 10'd1023; decim = 2'd0;
    enable = 1'b0;
    run_frame(2, 8, 1'b0);
    enable = 1'b1;
    for (int f = 0; f < 4; f++) run_frame(2, 8, 1'b0);
    // reset in the middle of an active line
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("midline_reset_async", 64'({pix_valid, pix_data, pix_x, pix_y, sof, line_done, eof, frame_act,
                                    frame_cnt, err_part, err_ovf}), 64'd0);
    @(posedge clk);
    #1;
    chk("midline_reset_edge", 64'({pix_valid, pix_data, pix_x, pix_y, sof, line_done, eof, frame_act,
                                   frame_cnt, err_part, err_ovf}), 64'd0);
    @(negedge clk);
    href = 1'b0;
    vsync = 1'b1;
    rst = 1'b0;
    mskip = 0; mcnt = '0; mpart = 1'b0; movf2 = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(2, 8, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
